// File: rtl/axi_addr_arb3.sv
// Three-port AXI address-channel arbiter with a registered downstream slot.
// Optional per-port grant counters are enabled by defining ARB_GRANT_CNT_EN.
module axi_addr_arb3 #(
    parameter int unsigned PLD_W = 64,
    parameter int unsigned CNT_W = 17
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              arb_en,
    input  logic [1:0]        arb_mode,
    input  logic [15:0]       weight_setting0,
    input  logic [15:0]       weight_setting1,
    input  logic [15:0]       weight_setting2,
    input  logic              s0_valid,
    input  logic [PLD_W-1:0]  s0_pld,
    output logic              s0_ready,
    input  logic              s1_valid,
    input  logic [PLD_W-1:0]  s1_pld,
    output logic              s1_ready,
    input  logic              s2_valid,
    input  logic [PLD_W-1:0]  s2_pld,
    output logic              s2_ready,
    output logic              m_valid,
    output logic [PLD_W-1:0]  m_pld,
    output logic [1:0]        m_port,
    input  logic              m_ready
`ifdef ARB_GRANT_CNT_EN
    ,
    output logic [31:0]       grant_cnt0,
    output logic [31:0]       grant_cnt1,
    output logic [31:0]       grant_cnt2
`endif
);

    typedef enum logic [1:0] {
        MODE_FIXED     = 2'd0,
        MODE_RR        = 2'd1,
        MODE_WRR       = 2'd2,
        MODE_FIXED_ALT = 2'd3
    } arb_mode_e;

    arb_mode_e          mode;
    logic [2:0]         req;
    logic               slot_free;
    logic               win_valid;
    logic [1:0]         win_idx;
    logic               grant;
    logic [PLD_W-1:0]   win_pld;
    logic [CNT_W-1:0]   limit;
    logic [15:0]        last_weight;
    logic [2:0]         last_onehot;

    logic               m_valid_q, m_valid_d;
    logic [PLD_W-1:0]   m_pld_q, m_pld_d;
    logic [1:0]         m_port_q, m_port_d;
    logic [1:0]         rr_ptr_q, rr_ptr_d;
    logic [1:0]         last_win_q, last_win_d;
    logic [CNT_W-1:0]   cons_cnt_q, cons_cnt_d;

    function automatic logic [1:0] next_port(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // First requester found when walking the ports cyclically from 'start'.
    function automatic logic [1:0] rr_pick(input logic [1:0] start, input logic [2:0] r);
        logic [1:0] c0, c1, c2;
        c0 = start;
        c1 = next_port(c0);
        c2 = next_port(c1);
        if (r[c0])      return c0;
        else if (r[c1]) return c1;
        else            return c2;
    endfunction

    assign mode      = arb_mode_e'(arb_mode);
    assign req       = {s2_valid, s1_valid, s0_valid};
    assign slot_free = !m_valid_q || m_ready;

    always_comb begin
        last_weight = weight_setting0;
        last_onehot = 3'b001;
        case (last_win_q)
            2'd1:    begin last_weight = weight_setting1; last_onehot = 3'b010; end
            2'd2:    begin last_weight = weight_setting2; last_onehot = 3'b100; end
            default: begin last_weight = weight_setting0; last_onehot = 3'b001; end
        endcase
        limit = {{(CNT_W-16){1'b0}}, last_weight} + CNT_W'(1);
    end

    always_comb begin
        win_valid = 1'b0;
        win_idx   = 2'd0;
        if (!arb_en) begin
            win_valid = req[0];
            win_idx   = 2'd0;
        end else begin
            win_valid = |req;
            case (mode)
                MODE_RR: win_idx = rr_pick(next_port(rr_ptr_q), req);
                MODE_WRR: begin
                    // Sole requester keeps winning even once its burst limit is used up.
                    if (req[last_win_q] &&
                        ((cons_cnt_q < limit) || ((req & ~last_onehot) == 3'b000)))
                        win_idx = last_win_q;
                    else
                        win_idx = rr_pick(next_port(last_win_q), req);
                end
                default: begin
                    if (req[0])      win_idx = 2'd0;
                    else if (req[1]) win_idx = 2'd1;
                    else             win_idx = 2'd2;
                end
            endcase
        end
    end

    assign grant    = rst_n && slot_free && win_valid;
    assign s0_ready = grant && (win_idx == 2'd0);
    assign s1_ready = grant && (win_idx == 2'd1);
    assign s2_ready = grant && (win_idx == 2'd2);

    always_comb begin
        case (win_idx)
            2'd1:    win_pld = s1_pld;
            2'd2:    win_pld = s2_pld;
            default: win_pld = s0_pld;
        endcase
    end

    always_comb begin
        m_valid_d  = m_valid_q;
        m_pld_d    = m_pld_q;
        m_port_d   = m_port_q;
        rr_ptr_d   = rr_ptr_q;
        last_win_d = last_win_q;
        cons_cnt_d = cons_cnt_q;
        if (grant) begin
            m_valid_d = 1'b1;
            m_pld_d   = win_pld;
            m_port_d  = win_idx;
            rr_ptr_d  = win_idx;
            if (win_idx == last_win_q) begin
                if (cons_cnt_q != '1)
                    cons_cnt_d = cons_cnt_q + CNT_W'(1);
            end else begin
                cons_cnt_d = CNT_W'(1);
                last_win_d = win_idx;
            end
        end else if (m_ready) begin
            m_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_valid_q  <= 1'b0;
            m_pld_q    <= '0;
            m_port_q   <= 2'd0;
            rr_ptr_q   <= 2'd2;
            last_win_q <= 2'd0;
            cons_cnt_q <= '0;
        end else begin
            m_valid_q  <= m_valid_d;
            m_pld_q    <= m_pld_d;
            m_port_q   <= m_port_d;
            rr_ptr_q   <= rr_ptr_d;
            last_win_q <= last_win_d;
            cons_cnt_q <= cons_cnt_d;
        end
    end

    assign m_valid = m_valid_q;
    assign m_pld   = m_pld_q;
    assign m_port  = m_port_q;

`ifdef ARB_GRANT_CNT_EN
    logic [31:0] grant_cnt0_q, grant_cnt1_q, grant_cnt2_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grant_cnt0_q <= '0;
            grant_cnt1_q <= '0;
            grant_cnt2_q <= '0;
        end else begin
            if (s0_ready) grant_cnt0_q <= grant_cnt0_q + 32'd1;
            if (s1_ready) grant_cnt1_q <= grant_cnt1_q + 32'd1;
            if (s2_ready) grant_cnt2_q <= grant_cnt2_q + 32'd1;
        end
    end

    assign grant_cnt0 = grant_cnt0_q;
    assign grant_cnt1 = grant_cnt1_q;
    assign grant_cnt2 = grant_cnt2_q;
`endif

endmodule

// File: tb/tb_axi_addr_arb3.sv
// Directed, table-driven bench for axi_addr_arb3 with a payload scoreboard
// and per-cycle ready/stall monitors.
module tb_axi_addr_arb3;

    localparam int unsigned PLD_W = 64;
    localparam int unsigned CNT_W = 17;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              arb_en;
    logic [1:0]        arb_mode;
    logic [15:0]       weight_setting0, weight_setting1, weight_setting2;
    logic              s0_valid, s1_valid, s2_valid;
    logic [PLD_W-1:0]  s0_pld, s1_pld, s2_pld;
    logic              s0_ready, s1_ready, s2_ready;
    logic              m_valid;
    logic [PLD_W-1:0]  m_pld;
    logic [1:0]        m_port;
    logic              m_ready;
`ifdef ARB_GRANT_CNT_EN
    logic [31:0]       grant_cnt0, grant_cnt1, grant_cnt2;
`endif

    always #5 clk = ~clk;

    axi_addr_arb3 #(.PLD_W(PLD_W), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .arb_en          (arb_en),
        .arb_mode        (arb_mode),
        .weight_setting0 (weight_setting0),
        .weight_setting1 (weight_setting1),
        .weight_setting2 (weight_setting2),
        .s0_valid        (s0_valid),
        .s0_pld          (s0_pld),
        .s0_ready        (s0_ready),
        .s1_valid        (s1_valid),
        .s1_pld          (s1_pld),
        .s1_ready        (s1_ready),
        .s2_valid        (s2_valid),
        .s2_pld          (s2_pld),
        .s2_ready        (s2_ready),
        .m_valid         (m_valid),
        .m_pld           (m_pld),
        .m_port          (m_port),
        .m_ready         (m_ready)
`ifdef ARB_GRANT_CNT_EN
        ,
        .grant_cnt0      (grant_cnt0),
        .grant_cnt1      (grant_cnt1),
        .grant_cnt2      (grant_cnt2)
`endif
    );

    typedef struct {
        logic       rst_n;
        logic       en;
        logic [1:0] mode;
        logic [2:0] v;
        logic       mr;
        logic [2:0] rdy;
        logic       mv;
        logic [1:0] mp;
    } vec_t;

    typedef struct {
        logic [PLD_W-1:0] pld;
        logic [1:0]       port;
    } beat_t;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;
    int unsigned step_cnt = 0;
    vec_t        tbl[$];
    beat_t       sb[$];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    function automatic vec_t mk(input int r, input int e, input int md, input int v,
                                input int mr, input int rdy, input int mv, input int mp);
        vec_t x;
        x.rst_n = 1'(r);
        x.en    = 1'(e);
        x.mode  = 2'(md);
        x.v     = 3'(v);
        x.mr    = 1'(mr);
        x.rdy   = 3'(rdy);
        x.mv    = 1'(mv);
        x.mp    = 2'(mp);
        return x;
    endfunction

    task automatic apply(input vec_t v, input string tag, input int idx);
        @(posedge clk);
        #1;
        step_cnt++;
        rst_n    = v.rst_n;
        arb_en   = v.en;
        arb_mode = v.mode;
        s0_valid = v.v[0];
        s1_valid = v.v[1];
        s2_valid = v.v[2];
        m_ready  = v.mr;
        s0_pld   = {32'd0, 32'(step_cnt)};
        s1_pld   = {32'd1, 32'(step_cnt)};
        s2_pld   = {32'd2, 32'(step_cnt)};
        @(negedge clk);
        chk($sformatf("%s[%0d].ready", tag, idx), 64'({s2_ready, s1_ready, s0_ready}), 64'(v.rdy));
        chk($sformatf("%s[%0d].m_valid", tag, idx), 64'(m_valid), 64'(v.mv));
        chk($sformatf("%s[%0d].m_port", tag, idx), 64'(m_port), 64'(v.mp));
    endtask

    // Scoreboard, at-most-one-ready and stall-stability monitors.
    logic             stall_prev = 1'b0;
    logic [PLD_W-1:0] stall_pld;
    logic [1:0]       stall_port;

    always @(negedge clk) begin
        beat_t b;
        if (m_valid === 1'b1 && m_ready === 1'b1) begin
            chk("sb_beat_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                b = sb.pop_front();
                chk("sb_pld", m_pld, b.pld);
                chk("sb_port", 64'(m_port), 64'(b.port));
            end
        end
        if (rst_n === 1'b1) begin
            if (s0_valid && s0_ready) begin b.pld = s0_pld; b.port = 2'd0; sb.push_back(b); end
            if (s1_valid && s1_ready) begin b.pld = s1_pld; b.port = 2'd1; sb.push_back(b); end
            if (s2_valid && s2_ready) begin b.pld = s2_pld; b.port = 2'd2; sb.push_back(b); end
        end
        chk("ready_onehot", 64'($countones({s2_ready, s1_ready, s0_ready}) <= 1), 64'd1);
        if (stall_prev) begin
            chk("stall_pld", m_pld, stall_pld);
            chk("stall_port", 64'(m_port), 64'(stall_port));
        end
        stall_prev = (rst_n === 1'b1) && (m_valid === 1'b1) && (m_ready === 1'b0);
        stall_pld  = m_pld;
        stall_port = m_port;
        if (rst_n !== 1'b1) sb.delete();
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; arb_en = 1'b1; arb_mode = 2'd0; m_ready = 1'b0;
        s0_valid = 1'b1; s1_valid = 1'b1; s2_valid = 1'b1;
        s0_pld = '0; s1_pld = '0; s2_pld = '0;
        weight_setting0 = 16'd2; weight_setting1 = 16'd0; weight_setting2 = 16'd1;
        repeat (2) @(posedge clk);

        //              rst en md  v      mr  rdy    mv mp
        // reset with all valid, then fixed priority
        tbl.push_back(mk(0, 1, 0, 'b111, 1, 'b000, 0, 0));
        tbl.push_back(mk(1, 1, 0, 'b111, 1, 'b001, 0, 0));
        tbl.push_back(mk(1, 1, 0, 'b111, 1, 'b001, 1, 0));
        tbl.push_back(mk(1, 1, 0, 'b111, 1, 'b001, 1, 0));
        tbl.push_back(mk(1, 1, 0, 'b111, 1, 'b001, 1, 0));
        tbl.push_back(mk(1, 1, 0, 'b111, 1, 'b001, 1, 0));
        tbl.push_back(mk(1, 1, 0, 'b111, 1, 'b001, 1, 0));
        tbl.push_back(mk(1, 1, 0, 'b110, 1, 'b010, 1, 0));
        tbl.push_back(mk(1, 1, 0, 'b110, 1, 'b010, 1, 1));
        tbl.push_back(mk(1, 1, 0, 'b000, 1, 'b000, 1, 1));
        tbl.push_back(mk(1, 1, 0, 'b000, 1, 'b000, 0, 1));
        // mode 3 behaves as fixed priority
        tbl.push_back(mk(1, 1, 3, 'b110, 1, 'b010, 0, 1));
        tbl.push_back(mk(1, 1, 3, 'b111, 1, 'b001, 1, 1));
        tbl.push_back(mk(1, 1, 3, 'b000, 1, 'b000, 1, 0));
        // round robin
        tbl.push_back(mk(0, 1, 1, 'b000, 1, 'b000, 0, 0));
        tbl.push_back(mk(1, 1, 1, 'b111, 1, 'b001, 0, 0));
        tbl.push_back(mk(1, 1, 1, 'b111, 1, 'b010, 1, 0));
        tbl.push_back(mk(1, 1, 1, 'b111, 1, 'b100, 1, 1));
        tbl.push_back(mk(1, 1, 1, 'b111, 1, 'b001, 1, 2));
        tbl.push_back(mk(1, 1, 1, 'b111, 1, 'b010, 1, 0));
        tbl.push_back(mk(1, 1, 1, 'b111, 1, 'b100, 1, 1));
        tbl.push_back(mk(1, 1, 1, 'b001, 1, 'b001, 1, 2));
        tbl.push_back(mk(1, 1, 1, 'b001, 1, 'b001, 1, 0));
        tbl.push_back(mk(1, 1, 1, 'b101, 1, 'b100, 1, 0));
        tbl.push_back(mk(1, 1, 1, 'b000, 1, 'b000, 1, 2));
        // weighted round robin, weights 2/0/1
        tbl.push_back(mk(0, 1, 2, 'b000, 1, 'b000, 0, 2));
        tbl.push_back(mk(1, 1, 2, 'b111, 1, 'b001, 0, 0));
        tbl.push_back(mk(1, 1, 2, 'b111, 1, 'b001, 1, 0));
        tbl.push_back(mk(1, 1, 2, 'b111, 1, 'b001, 1, 0));
        tbl.push_back(mk(1, 1, 2, 'b111, 1, 'b010, 1, 0));
        tbl.push_back(mk(1, 1, 2, 'b111, 1, 'b100, 1, 1));
        tbl.push_back(mk(1, 1, 2, 'b111, 1, 'b100, 1, 2));
        tbl.push_back(mk(1, 1, 2, 'b111, 1, 'b001, 1, 2));
        tbl.push_back(mk(1, 1, 2, 'b111, 1, 'b001, 1, 0));
        tbl.push_back(mk(1, 1, 2, 'b111, 1, 'b001, 1, 0));
        tbl.push_back(mk(1, 1, 2, 'b001, 1, 'b001, 1, 0));
        tbl.push_back(mk(1, 1, 2, 'b011, 1, 'b010, 1, 0));
        tbl.push_back(mk(1, 1, 2, 'b000, 1, 'b000, 1, 1));
        // backpressure: 5 stalled cycles
        tbl.push_back(mk(1, 1, 2, 'b111, 0, 'b100, 0, 1));
        tbl.push_back(mk(1, 1, 2, 'b111, 0, 'b000, 1, 2));
        tbl.push_back(mk(1, 1, 2, 'b111, 0, 'b000, 1, 2));
        tbl.push_back(mk(1, 1, 2, 'b111, 0, 'b000, 1, 2));
        tbl.push_back(mk(1, 1, 2, 'b111, 0, 'b000, 1, 2));
        tbl.push_back(mk(1, 1, 2, 'b111, 0, 'b000, 1, 2));
        tbl.push_back(mk(1, 1, 2, 'b111, 1, 'b100, 1, 2));
        tbl.push_back(mk(1, 1, 2, 'b111, 1, 'b001, 1, 2));
        // arbitration disabled: port 0 only
        tbl.push_back(mk(1, 0, 2, 'b111, 1, 'b001, 1, 0));
        tbl.push_back(mk(1, 0, 2, 'b110, 1, 'b000, 1, 0));
        tbl.push_back(mk(1, 0, 2, 'b111, 1, 'b001, 0, 0));
        tbl.push_back(mk(1, 0, 2, 'b111, 1, 'b001, 1, 0));
        // reset with a stalled beat pending
        tbl.push_back(mk(0, 1, 0, 'b111, 0, 'b000, 1, 0));
        tbl.push_back(mk(1, 1, 0, 'b000, 0, 'b000, 0, 0));

        foreach (tbl[i]) apply(tbl[i], "tbl", i);

        // Mode switch mid-burst must not clear the consecutive-grant count.
        apply(mk(0, 1, 2, 'b000, 1, 'b000, 0, 0), "modesw", 0);
        apply(mk(1, 1, 2, 'b111, 1, 'b001, 0, 0), "modesw", 1);
        apply(mk(1, 1, 2, 'b111, 1, 'b001, 1, 0), "modesw", 2);
        apply(mk(1, 1, 0, 'b111, 1, 'b001, 1, 0), "modesw", 3);
        apply(mk(1, 1, 2, 'b111, 1, 'b010, 1, 0), "modesw", 4);
        apply(mk(1, 1, 2, 'b000, 1, 'b000, 1, 1), "modesw", 5);

        @(posedge clk);
        #1;
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
